// File: rtl/mem_ctl_pkg.sv
// rtl/mem_ctl_pkg.sv - shared memory-controller command codes and bus widths
package mem_ctl_pkg;

  localparam int CMD_W  = 2;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 64;

  typedef logic [CMD_W-1:0] mem_cmd_t;

  localparam mem_cmd_t CMD_NOOP    = 2'd0;
  localparam mem_cmd_t CMD_REFRESH = 2'd1;
  localparam mem_cmd_t CMD_READ    = 2'd2;
  localparam mem_cmd_t CMD_WRITE   = 2'd3;

endpackage

// File: rtl/mem_req_arbiter_tag_fifo.sv
// rtl/mem_req_arbiter_tag_fifo.sv - in-order FIFO of requester ids for outstanding reads
module tag_fifo #(
  parameter int W          = 2,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [W-1:0]          head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  logic [W-1:0]            mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = count[DEPTH_LOG2];
  assign empty = (count == '0);

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin burst-locked sharing of mem_ctl request/response FIFOs
module mem_req_arbiter
  import mem_ctl_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int BURST_LEN      = 8,
  parameter int TAG_DEPTH_LOG2 = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [CMD_W*NREQ-1:0]    req_cmd,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [DATA_W*NREQ-1:0]   req_dta,
  output logic [NREQ-1:0]          req_ack,
  output logic                     mem_req_wr_en,
  output logic [CMD_W-1:0]         mem_req_wr_cmd,
  output logic [ADDR_W-1:0]        mem_req_wr_addr,
  output logic [DATA_W-1:0]        mem_req_wr_dta,
  input  logic                     mem_req_wr_almost_full,
  input  logic                     mem_res_empty,
  output logic                     mem_res_rd_en,
  input  logic                     mem_res_rd_valid,
  input  logic [DATA_W-1:0]        mem_res_rd_dta,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_dta,
  output logic                     error
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]          holder;
  logic [7:0]              burst_cnt;
  logic                    locked;
  logic [NREQ-1:0]         eligible;
  logic                    grant_vld;
  logic                    grant_keep;
  logic [IDW-1:0]          grant_idx;
  logic [IDW-1:0]          cand;
  mem_cmd_t                sel_cmd;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_dta;
  logic                    tag_push;
  logic                    tag_full;
  logic                    tag_empty;
  logic [IDW-1:0]          tag_head;
  logic [TAG_DEPTH_LOG2:0] tag_count;
  logic [IDW-1:0]          id_pipe;
  logic                    id_vld;
  logic                    orphan_q;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++)
      eligible[i] = req_valid[i] & ~mem_req_wr_almost_full &
                    ((req_cmd[CMD_W*i +: CMD_W] != CMD_READ) | ~tag_full);
  end

  // Keep the burst holder while it stays eligible; otherwise rotate starting after it.
  always_comb begin
    grant_vld  = 1'b0;
    grant_keep = 1'b0;
    grant_idx  = holder;
    cand       = holder;
    if (!rst) begin
      if (locked && eligible[holder] && (burst_cnt < 8'(BURST_LEN))) begin
        grant_vld  = 1'b1;
        grant_keep = 1'b1;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          cand = IDW'((int'(holder) + k) % NREQ);
          if (!grant_vld && eligible[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
          end
        end
      end
    end
  end

  always_comb begin
    sel_cmd  = CMD_NOOP;
    sel_addr = '0;
    sel_dta  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_idx) begin
        sel_cmd  = req_cmd[CMD_W*i +: CMD_W];
        sel_addr = req_addr[ADDR_W*i +: ADDR_W];
        sel_dta  = req_dta[DATA_W*i +: DATA_W];
      end
    end
  end

  assign req_ack       = grant_vld ? (NREQ'(1) << grant_idx) : '0;
  assign tag_push      = grant_vld && (sel_cmd == CMD_READ);
  assign mem_res_rd_en = ~rst & ~mem_res_empty & ~tag_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      holder          <= IDW'(NREQ - 1);
      burst_cnt       <= '0;
      locked          <= 1'b0;
      mem_req_wr_en   <= 1'b0;
      mem_req_wr_cmd  <= '0;
      mem_req_wr_addr <= '0;
      mem_req_wr_dta  <= '0;
    end else begin
      mem_req_wr_en <= grant_vld;
      if (grant_vld) begin
        mem_req_wr_cmd  <= sel_cmd;
        mem_req_wr_addr <= sel_addr;
        mem_req_wr_dta  <= sel_dta;
        holder          <= grant_idx;
        burst_cnt       <= grant_keep ? burst_cnt + 8'd1 : 8'd1;
        locked          <= 1'b1;
      end else begin
        locked <= 1'b0;
      end
    end
  end

  tag_fifo #(
    .W          (IDW),
    .DEPTH_LOG2 (TAG_DEPTH_LOG2)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (grant_idx),
    .pop       (mem_res_rd_en),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  // Data returned with no id in flight, or a non-empty response FIFO with no read
  // outstanding for two consecutive cycles, means the memory side lost sync.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pipe   <= '0;
      id_vld    <= 1'b0;
      rsp_valid <= '0;
      rsp_dta   <= '0;
      orphan_q  <= 1'b0;
      error     <= 1'b0;
    end else begin
      id_vld <= mem_res_rd_en;
      if (mem_res_rd_en) id_pipe <= tag_head;
      rsp_valid <= (mem_res_rd_valid && id_vld) ? (NREQ'(1) << id_pipe) : '0;
      if (mem_res_rd_valid) rsp_dta <= mem_res_rd_dta;
      orphan_q <= ~mem_res_empty & (tag_count == '0);
      if ((mem_res_rd_valid && !id_vld) ||
          (orphan_q && !mem_res_empty && (tag_count == '0)))
        error <= 1'b1;
    end
  end

endmodule
